// File: rtl/fml_pkg.sv
// Shared FML constants and the arbiter state encoding, reused by the FML-side blocks.
package fml_pkg;

  localparam int unsigned FML_DW        = 64;
  localparam int unsigned FML_SEL_W     = FML_DW / 8;
  localparam int unsigned FML_BURST_LEN = 4;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBurst
  } fml_state_e;

  // Index width that stays at least 1 bit for degenerate counts.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fml_arb_rr.sv
// Rotating priority encoder: first set request bit at or above rr_ptr, wrapping modulo n_masters.
module fml_arb_rr
  import fml_pkg::*;
#(
  parameter int unsigned n_masters = 4,
  parameter int unsigned gw        = idx_width(n_masters)
) (
  input  logic [n_masters-1:0] req,
  input  logic [gw-1:0]        rr_ptr,
  output logic [gw-1:0]        winner,
  output logic                 any_req
);

  localparam logic [gw-1:0] LastIdx = gw'(n_masters - 1);

  always_comb begin
    logic [gw-1:0] idx;
    logic          found;
    winner = '0;
    found  = 1'b0;
    idx    = rr_ptr;
    for (int unsigned i = 0; i < n_masters; i++) begin
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
      // Explicit wrap: n_masters need not be a power of two.
      idx = (idx == LastIdx) ? '0 : idx + 1'b1;
    end
    any_req = |req;
  end

endmodule

// File: rtl/fml_arb.sv
// Round-robin arbiter sharing one FML slave port between n_masters masters; the grant is held
// through the fixed-length data burst so the data-path muxes stay stable.
module fml_arb
  import fml_pkg::*;
#(
  parameter int unsigned adr_width = 30,
  parameter int unsigned n_masters = 4,
  parameter int unsigned dw        = FML_DW,
  parameter int unsigned burst_len = FML_BURST_LEN
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [n_masters*adr_width-1:0] m_adr,
  input  logic [n_masters-1:0]          m_stb,
  input  logic [n_masters-1:0]          m_we,
  input  logic [n_masters*dw/8-1:0]     m_sel,
  input  logic [n_masters*dw-1:0]       m_di,
  output logic [n_masters-1:0]          m_ack,
  output logic [dw-1:0]                 m_do,
  output logic [adr_width-1:0]          s_adr,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [dw/8-1:0]               s_sel,
  output logic [dw-1:0]                 s_di,
  input  logic                          s_ack,
  input  logic [dw-1:0]                 s_do
);

  localparam int unsigned sel_w = dw / 8;
  localparam int unsigned gw    = idx_width(n_masters);
  localparam int unsigned bw    = idx_width(burst_len);

  localparam logic [gw-1:0] LastGrant = gw'(n_masters - 1);
  localparam logic [bw-1:0] LastBeat  = bw'(burst_len - 1);

  logic [adr_width-1:0] adr_arr [n_masters];
  logic [sel_w-1:0]     sel_arr [n_masters];
  logic [dw-1:0]        di_arr  [n_masters];

  for (genvar i = 0; i < n_masters; i++) begin : g_unpack
    assign adr_arr[i] = m_adr[i*adr_width +: adr_width];
    assign sel_arr[i] = m_sel[i*sel_w +: sel_w];
    assign di_arr[i]  = m_di[i*dw +: dw];
  end

  fml_state_e           state_q;
  logic [gw-1:0]        grant_q;
  logic [gw-1:0]        rr_ptr_q;
  logic [bw-1:0]        beat_cnt_q;
  logic [adr_width-1:0] adr_q;
  logic                 we_q;
  logic [sel_w-1:0]     sel_q;

  logic [gw-1:0] winner;
  logic          any_req;

  fml_arb_rr #(
    .n_masters(n_masters),
    .gw       (gw)
  ) u_rr (
    .req    (m_stb),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .any_req(any_req)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      adr_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q <= winner;
            adr_q   <= adr_arr[winner];
            we_q    <= m_we[winner];
            sel_q   <= sel_arr[winner];
            state_q <= StReq;
          end
        end
        StReq: begin
          if (s_ack) begin
            beat_cnt_q <= '0;
            state_q    <= StBurst;
          end
        end
        StBurst: begin
          beat_cnt_q <= beat_cnt_q + 1'b1;
          if (beat_cnt_q == LastBeat) begin
            state_q  <= StIdle;
            rr_ptr_q <= (grant_q == LastGrant) ? '0 : grant_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_stb = (state_q == StReq);
  assign s_adr = adr_q;
  assign s_we  = we_q;
  assign s_sel = sel_q;
  assign s_di  = di_arr[grant_q];
  assign m_do  = s_do;

  // Ack is a same-cycle pass-through, only while the granted request is outstanding.
  always_comb begin
    m_ack = '0;
    if (state_q == StReq) m_ack[grant_q] = s_ack;
  end

endmodule

// File: tb/tb_fml_arb.sv
// Directed bench for fml_arb: single read/write, round-robin order, request latching, mid-burst
// reset.
module tb_fml_arb;

  localparam int unsigned AW = 30;
  localparam int unsigned NM = 4;
  localparam int unsigned DW = 64;

  logic                 sys_clk;
  logic                 sys_rst;
  logic [NM*AW-1:0]     m_adr;
  logic [NM-1:0]        m_stb;
  logic [NM-1:0]        m_we;
  logic [NM*DW/8-1:0]   m_sel;
  logic [NM*DW-1:0]     m_di;
  logic [NM-1:0]        m_ack;
  logic [DW-1:0]        m_do;
  logic [AW-1:0]        s_adr;
  logic                 s_stb;
  logic                 s_we;
  logic [DW/8-1:0]      s_sel;
  logic [DW-1:0]        s_di;
  logic                 s_ack;
  logic [DW-1:0]        s_do;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] rd_beats [4] = '{64'haaaa_aaaa_aaaa_aaaa, 64'hbbbb_bbbb_bbbb_bbbb,
                                  64'hcccc_cccc_cccc_cccc, 64'hdddd_dddd_dddd_dddd};
  logic [DW-1:0] wr_beats [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};

  fml_arb #(
    .adr_width(AW),
    .n_masters(NM),
    .dw       (DW),
    .burst_len(4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .m_adr  (m_adr),
    .m_stb  (m_stb),
    .m_we   (m_we),
    .m_sel  (m_sel),
    .m_di   (m_di),
    .m_ack  (m_ack),
    .m_do   (m_do),
    .s_adr  (s_adr),
    .s_stb  (s_stb),
    .s_we   (s_we),
    .s_sel  (s_sel),
    .s_di   (s_di),
    .s_ack  (s_ack),
    .s_do   (s_do)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sets m_stb in an IDLE cycle; ends in the IDLE cycle after the burst.
  task automatic do_txn(input logic [3:0] exp_ack, input logic [29:0] exp_adr,
                        input logic exp_we, input logic [3:0] stb_after, input string tag);
    tick();
    #1;
    chk({tag, "_stb"}, 64'(s_stb), 64'd1);
    chk({tag, "_adr"}, 64'(s_adr), 64'(exp_adr));
    chk({tag, "_we"}, 64'(s_we), 64'(exp_we));
    s_ack = 1'b1;
    #1;
    chk({tag, "_ack"}, 64'(m_ack), 64'(exp_ack));
    m_stb = stb_after;
    tick();
    s_ack = 1'b0;
    repeat (3) tick();
    #1;
    chk({tag, "_burst_ack"}, 64'(m_ack), 64'd0);
    chk({tag, "_burst_stb"}, 64'(s_stb), 64'd0);
    tick();
    #1;
    chk({tag, "_idle_stb"}, 64'(s_stb), 64'd0);
  endtask

  initial begin
    logic [3:0] one_hot;
    logic [3:0] rest;
    sys_rst = 1'b1;
    m_adr   = '0;
    m_stb   = '0;
    m_we    = '0;
    m_sel   = '0;
    m_di    = '0;
    s_ack   = 1'b0;
    s_do    = '0;

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_stb", 64'(s_stb), 64'd0);
    chk("rst_ack", 64'(m_ack), 64'd0);
    chk("rst_adr", 64'(s_adr), 64'd0);
    chk("rst_we", 64'(s_we), 64'd0);
    chk("rst_sel", 64'(s_sel), 64'd0);

    // 1: single read by master 2, slave acks 3 cycles after s_stb
    sys_rst = 1'b0;
    m_adr[2*AW +: AW] = 30'h100;
    m_stb = 4'b0100;
    #1;
    chk("t1_idle_stb", 64'(s_stb), 64'd0);
    tick();
    #1;
    chk("t1_req_stb", 64'(s_stb), 64'd1);
    chk("t1_req_adr", 64'(s_adr), 64'h100);
    chk("t1_req_we", 64'(s_we), 64'd0);
    chk("t1_req_noack", 64'(m_ack), 64'd0);
    tick();
    tick();
    #1;
    chk("t1_wait_stb", 64'(s_stb), 64'd1);
    tick();
    s_ack = 1'b1;
    #1;
    chk("t1_ack", 64'(m_ack), 64'b0100);
    tick();
    s_ack = 1'b0;
    m_stb = '0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      s_do = rd_beats[b];
      #1;
      chk("t1_m_do", m_do, rd_beats[b]);
      chk("t1_beat_ack", 64'(m_ack), 64'd0);
      chk("t1_beat_stb", 64'(s_stb), 64'd0);
    end
    tick();
    #1;
    chk("t1_end_stb", 64'(s_stb), 64'd0);

    // 2: single write by master 1 (pointer now 3, wraps to 1)
    m_adr[1*AW +: AW] = 30'h200;
    m_we = 4'b0010;
    m_sel[8 +: 8] = 8'hff;
    m_di[0 +: DW] = 64'hdead_beef_dead_beef;
    m_stb = 4'b0010;
    tick();
    #1;
    chk("t2_stb", 64'(s_stb), 64'd1);
    chk("t2_adr", 64'(s_adr), 64'h200);
    chk("t2_we", 64'(s_we), 64'd1);
    chk("t2_sel", 64'(s_sel), 64'hff);
    s_ack = 1'b1;
    #1;
    chk("t2_ack", 64'(m_ack), 64'b0010);
    tick();
    s_ack = 1'b0;
    m_stb = '0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      m_di[1*DW +: DW] = wr_beats[b];
      #1;
      chk("t2_s_di", s_di, wr_beats[b]);
      chk("t2_beat_ack", 64'(m_ack), 64'd0);
    end
    tick();
    #1;
    chk("t2_end_stb", 64'(s_stb), 64'd0);

    // 3: all four request together from reset -> grants 0,1,2,3
    sys_rst = 1'b1;
    m_we = '0;
    tick();
    sys_rst = 1'b0;
    #1;
    chk("t3_rst_adr", 64'(s_adr), 64'd0);
    for (int g = 0; g < 4; g++) m_adr[g*AW +: AW] = 30'h10 + 30'(g);
    m_stb = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      one_hot = 4'b0001 << g;
      rest    = 4'b1111 << (g + 1);
      do_txn(one_hot, 30'h10 + 30'(g), 1'b0, rest, "t3");
    end

    // 4: masters 0 and 3 continuous -> alternate 0,3,0,3
    m_stb = 4'b1001;
    do_txn(4'b0001, 30'h10, 1'b0, 4'b1001, "t4_a");
    do_txn(4'b1000, 30'h13, 1'b0, 4'b1001, "t4_b");
    do_txn(4'b0001, 30'h10, 1'b0, 4'b1001, "t4_c");
    do_txn(4'b1000, 30'h13, 1'b0, 4'b0000, "t4_d");

    // 5: master 0 drops stb and changes adr during REQ; latched request holds
    m_adr[0 +: AW] = 30'h3c;
    m_stb = 4'b0001;
    tick();
    m_stb = '0;
    m_adr[0 +: AW] = 30'h77;
    #1;
    chk("t5_stb", 64'(s_stb), 64'd1);
    chk("t5_adr", 64'(s_adr), 64'h3c);
    tick();
    #1;
    chk("t5_hold_stb", 64'(s_stb), 64'd1);
    chk("t5_hold_adr", 64'(s_adr), 64'h3c);
    chk("t5_hold_noack", 64'(m_ack), 64'd0);
    s_ack = 1'b1;
    #1;
    chk("t5_ack", 64'(m_ack), 64'b0001);
    tick();
    s_ack = 1'b0;
    repeat (3) tick();
    tick();
    #1;
    chk("t5_end_stb", 64'(s_stb), 64'd0);

    // 6: reset during beat 2 of a master-2 burst
    m_adr[2*AW +: AW] = 30'h123;
    m_stb = 4'b0100;
    tick();
    #1;
    chk("t6_adr", 64'(s_adr), 64'h123);
    s_ack = 1'b1;
    m_stb = '0;
    #1;
    chk("t6_ack", 64'(m_ack), 64'b0100);
    tick();
    s_ack = 1'b0;
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    #1;
    chk("t6_rst_stb", 64'(s_stb), 64'd0);
    chk("t6_rst_ack", 64'(m_ack), 64'd0);
    chk("t6_rst_adr", 64'(s_adr), 64'd0);
    s_ack = 1'b1;
    #1;
    chk("t6_stray_ack", 64'(m_ack), 64'd0);
    s_ack = 1'b0;
    // Pointer back at 0: {3,0} must pick master 0
    m_adr[0 +: AW] = 30'h3a;
    m_adr[3*AW +: AW] = 30'h3b;
    m_stb = 4'b1001;
    do_txn(4'b0001, 30'h3a, 1'b0, 4'b0000, "t6_ptr");
    m_adr[1*AW +: AW] = 30'h2b;
    m_stb = 4'b0010;
    do_txn(4'b0010, 30'h2b, 1'b0, 4'b0000, "t6_m1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
